// File: rtl/pipelined_adder.sv
// pipelined_adder: WIDTH-bit add/sub split into STAGES chunk-wide stages,
// carry registered stage to stage, valid/ready on both ends.
//
// Ports:
//   CLK, RST             clock, synchronous active-high reset
//   IN_VALID / IN_READY  operand handshake (A, B, C_IN, SUB)
//   OUT_VALID / OUT_READY result handshake (SUM, CARRY, OVERFLOW)
//   SUB=0: SUM = A+B+C_IN ; SUB=1: SUM = A-B (C_IN ignored)
//   CARRY: carry out of MSB (for SUB, 1 = no borrow)
//   OVERFLOW: two's-complement signed overflow

module pipelined_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 4
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             C_IN,
    input  logic             SUB,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [WIDTH-1:0] SUM,
    output logic             CARRY,
    output logic             OVERFLOW
);

    localparam int CHUNK = (STAGES > 0) ? (WIDTH / STAGES) : 1;

    generate
        if ((WIDTH < 1) || (STAGES < 1) || (STAGES > WIDTH) ||
            ((WIDTH % CHUNK) != 0) || ((CHUNK * STAGES) != WIDTH))
        begin : g_bad_params
            $error("pipelined_adder: WIDTH must split into STAGES equal chunks");
        end
    endgenerate

    // Stage inputs (combinational view of what each stage adds this cycle)
    logic [WIDTH-1:0] in_a [STAGES];
    logic [WIDTH-1:0] in_b [STAGES];
    logic [WIDTH-1:0] in_s [STAGES];
    logic             in_c [STAGES];
    logic             in_v [STAGES];
    logic [CHUNK:0]   add  [STAGES];

    // Stage registers
    logic [WIDTH-1:0] a_q [STAGES];
    logic [WIDTH-1:0] b_q [STAGES];
    logic [WIDTH-1:0] s_q [STAGES];
    logic             c_q [STAGES];
    logic             v_q [STAGES];
    logic             ovf_q;

    logic adv;
    logic ovf_d;

    assign adv      = !v_q[STAGES-1] || OUT_READY;
    assign IN_READY = adv && !RST;

    // Operands shift right by CHUNK each stage so the chunk being added is
    // always the low CHUNK bits; finished sum chunks enter from the top and
    // shift down, landing in place after the last stage.
    always_comb begin
        in_a[0] = A;
        in_b[0] = SUB ? ~B : B;
        in_c[0] = SUB | C_IN;
        in_v[0] = IN_VALID && IN_READY;
        in_s[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            in_a[k] = a_q[k-1];
            in_b[k] = b_q[k-1];
            in_c[k] = c_q[k-1];
            in_v[k] = v_q[k-1];
            in_s[k] = s_q[k-1];
        end
        for (int k = 0; k < STAGES; k++) begin
            add[k] = {1'b0, in_a[k][CHUNK-1:0]}
                   + {1'b0, in_b[k][CHUNK-1:0]}
                   + {{CHUNK{1'b0}}, in_c[k]};
        end
    end

    // Last stage holds the MSB chunk of A and effective B.
    assign ovf_d = (in_a[STAGES-1][CHUNK-1] == in_b[STAGES-1][CHUNK-1]) &&
                   (add[STAGES-1][CHUNK-1] != in_a[STAGES-1][CHUNK-1]);

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= 1'b0;
                c_q[k] <= 1'b0;
                a_q[k] <= '0;
                b_q[k] <= '0;
                s_q[k] <= '0;
            end
            ovf_q <= 1'b0;
        end else if (adv) begin
            for (int k = 0; k < STAGES; k++) begin
                v_q[k] <= in_v[k];
                c_q[k] <= add[k][CHUNK];
                a_q[k] <= in_a[k] >> CHUNK;
                b_q[k] <= in_b[k] >> CHUNK;
                s_q[k] <= (in_s[k] >> CHUNK) |
                          (WIDTH'(add[k][CHUNK-1:0]) << (WIDTH - CHUNK));
            end
            ovf_q <= ovf_d;
        end
    end

    assign OUT_VALID = v_q[STAGES-1];
    assign SUM       = s_q[STAGES-1];
    assign CARRY     = c_q[STAGES-1];
    assign OVERFLOW  = ovf_q;

endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed vectors plus a queue-based result model
// for pipelined_adder (16 bits; 4 stages, with 1- and 16-stage siblings).

module tb_pipelined_adder;

    localparam int W = 16;
    localparam int S = 4;

    typedef struct packed {
        logic [W-1:0] sum;
        logic         carry;
        logic         ovf;
    } res_t;

    logic         CLK = 1'b0;
    logic         RST;
    logic         IN_VALID;
    logic         IN_READY;
    logic [W-1:0] A;
    logic [W-1:0] B;
    logic         C_IN;
    logic         SUB;
    logic         OUT_VALID;
    logic         OUT_READY;
    logic [W-1:0] SUM;
    logic         CARRY;
    logic         OVERFLOW;

    logic         s1_in_ready, s1_valid, s1_carry, s1_ovf;
    logic [W-1:0] s1_sum;
    logic         s16_in_ready, s16_valid, s16_carry, s16_ovf;
    logic [W-1:0] s16_sum;

    int checks   = 0;
    int failures = 0;

    res_t exp_q[$];
    logic         stall_prev = 1'b0;
    logic [W-1:0] held_sum;
    logic         held_carry, held_ovf;

    always #5 CLK = ~CLK;

    pipelined_adder #(.WIDTH(W), .STAGES(S)) dut (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .A(A), .B(B), .C_IN(C_IN), .SUB(SUB),
        .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .SUM(SUM), .CARRY(CARRY), .OVERFLOW(OVERFLOW)
    );

    pipelined_adder #(.WIDTH(W), .STAGES(1)) dut_s1 (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(s1_in_ready),
        .A(A), .B(B), .C_IN(C_IN), .SUB(SUB),
        .OUT_VALID(s1_valid), .OUT_READY(OUT_READY),
        .SUM(s1_sum), .CARRY(s1_carry), .OVERFLOW(s1_ovf)
    );

    pipelined_adder #(.WIDTH(W), .STAGES(16)) dut_s16 (
        .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(s16_in_ready),
        .A(A), .B(B), .C_IN(C_IN), .SUB(SUB),
        .OUT_VALID(s16_valid), .OUT_READY(OUT_READY),
        .SUM(s16_sum), .CARRY(s16_carry), .OVERFLOW(s16_ovf)
    );

    function automatic res_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin, input logic sub);
        res_t r;
        int   ua, ub, sa, sb, ures, sres, sgot;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            ures    = ua - ub;
            sres    = sa - sb;
            r.carry = (ua >= ub);
        end else begin
            ures    = ua + ub + int'(cin);
            sres    = sa + sb + int'(cin);
            r.carry = (ures > 32'hFFFF);
        end
        r.sum = ures[W-1:0];
        sgot  = int'($signed(r.sum));
        r.ovf = (sgot != sres);
        return r;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Scoreboard: one compare per meaningful cycle, sampled on negedge.
    always @(negedge CLK) begin
        if (RST) begin
            exp_q.delete();
            stall_prev = 1'b0;
            chk("in_ready_rst", 32'(IN_READY), 32'd0);
        end else begin
            if (stall_prev) begin
                chk("stall_valid", 32'(OUT_VALID), 32'd1);
                chk("stall_hold", {15'd0, SUM, CARRY}, {15'd0, held_sum, held_carry});
                chk("stall_ovf", 32'(OVERFLOW), 32'(held_ovf));
            end
            if (OUT_VALID) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_out", 32'(OUT_VALID), 32'd0);
                end else begin
                    chk("sb_result", {14'd0, SUM, CARRY, OVERFLOW},
                        {14'd0, exp_q[0].sum, exp_q[0].carry, exp_q[0].ovf});
                    if (OUT_READY) void'(exp_q.pop_front());
                end
            end
            if (OUT_VALID && !OUT_READY)
                chk("in_ready_stall", 32'(IN_READY), 32'd0);
            else
                chk("in_ready_free", 32'(IN_READY), 32'd1);
            stall_prev = OUT_VALID && !OUT_READY;
            held_sum   = SUM;
            held_carry = CARRY;
            held_ovf   = OVERFLOW;
            if (IN_VALID && IN_READY) exp_q.push_back(model(A, B, C_IN, SUB));
        end
    end

    task automatic run_one(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic cin, input logic sub,
                           input logic [W-1:0] es, input logic ec, input logic eo);
        A = a; B = b; C_IN = cin; SUB = sub;
        IN_VALID  = 1'b1;
        OUT_READY = 1'b1;
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
        for (int e = 0; e <= S; e++) begin
            @(negedge CLK);
            chk("lat_valid", 32'(OUT_VALID), 32'(e == S - 1));
            if (e == S - 1)
                chk("lat_result", {14'd0, SUM, CARRY, OVERFLOW},
                    {14'd0, es, ec, eo});
            @(posedge CLK);
        end
        #1;
    endtask

    initial begin
        RST = 1'b1; IN_VALID = 1'b0; A = '0; B = '0;
        C_IN = 1'b0; SUB = 1'b0; OUT_READY = 1'b1;
        repeat (3) @(posedge CLK);
        #1 RST = 1'b0;

        @(negedge CLK);
        chk("rst_state", {14'd0, OUT_VALID, SUM, CARRY, OVERFLOW}, 32'd0);
        @(posedge CLK);
        #1;

        // Pin the model with hand-computed values.
        chk("model_add", 32'(model(16'h00FF, 16'h0001, 1'b0, 1'b0)), {14'd0, 16'h0100, 2'b00});
        chk("model_rip", 32'(model(16'hFFFF, 16'h0000, 1'b1, 1'b0)), {14'd0, 16'h0000, 2'b10});
        chk("model_ovf", 32'(model(16'h7FFF, 16'h0001, 1'b0, 1'b0)), {14'd0, 16'h8000, 2'b01});
        chk("model_sub", 32'(model(16'h0005, 16'h0007, 1'b1, 1'b1)), {14'd0, 16'hFFFE, 2'b00});
        chk("model_sov", 32'(model(16'h8000, 16'h0001, 1'b0, 1'b1)), {14'd0, 16'h7FFF, 2'b11});

        // 0xFFFF + 0x0001 through 1-, 4- and 16-stage pipelines.
        A = 16'hFFFF; B = 16'h0001; C_IN = 1'b0; SUB = 1'b0;
        IN_VALID = 1'b1;
        @(posedge CLK);
        #1 IN_VALID = 1'b0;
        for (int e = 0; e <= 16; e++) begin
            @(negedge CLK);
            chk("s1_valid", 32'(s1_valid), 32'(e == 0));
            chk("s4_valid", 32'(OUT_VALID), 32'(e == S - 1));
            chk("s16_valid", 32'(s16_valid), 32'(e == 15));
            if (e == 0)  chk("s1_res", {15'd0, s1_sum, s1_carry}, {15'd0, 16'h0000, 1'b1});
            if (e == 3)  chk("s4_res", {15'd0, SUM, CARRY}, {15'd0, 16'h0000, 1'b1});
            if (e == 15) chk("s16_res", {15'd0, s16_sum, s16_carry}, {15'd0, 16'h0000, 1'b1});
            @(posedge CLK);
        end
        #1;
        chk("s1_rdy", 32'(s1_in_ready && s16_in_ready), 32'd1);

        run_one(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
        run_one(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_one(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_one(16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);

        // Back-to-back stream with OUT_READY low for cycles 6..9.
        begin
            int   idx;
            int   c;
            logic acc;
            idx = 1;
            c   = 0;
            while ((idx <= 8 || exp_q.size() != 0) && c < 200) begin
                IN_VALID  = (idx <= 8);
                A         = 16'(idx);
                B         = 16'(idx * 32'h1000);
                C_IN      = 1'b0;
                SUB       = 1'b0;
                OUT_READY = !(c >= 6 && c <= 9);
                @(negedge CLK);
                acc = IN_VALID && IN_READY;
                @(posedge CLK);
                #1;
                if (acc) idx++;
                c++;
            end
            IN_VALID  = 1'b0;
            OUT_READY = 1'b1;
            chk("stream_done", 32'(idx), 32'd9);
            chk("stream_drain", 32'(exp_q.size()), 32'd0);
        end

        // Reset with three transactions in flight.
        for (int i = 1; i <= 3; i++) begin
            A = 16'(i); B = 16'h0100; IN_VALID = 1'b1;
            @(posedge CLK);
            #1;
        end
        IN_VALID = 1'b0;
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge CLK);
            chk("flush_valid", 32'(OUT_VALID), 32'd0);
        end
        @(posedge CLK);
        #1;
        run_one(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

        repeat (2) @(posedge CLK);
        #1;
        chk("final_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipelined_adder.md
Name: pipelined_adder

Overview:
- Parametrised, pipelined WIDTH-bit adder/subtractor. It is the multi-bit, registered successor to the single-bit full adder.
- Splits the operands into STAGES equal chunks. Each chunk is added in its own pipeline stage, and the carry is passed stage to stage through registers.
- Valid/ready handshakes on input and output let it sit in the neighbour-count and generation-counter datapaths with backpressure.

Parameters:
- WIDTH, 16, operand/result width in bits; must be >= 1.
- STAGES, 4, number of pipeline stages; 1 <= STAGES <= WIDTH; WIDTH % STAGES == 0 (elaboration-time assertion). CHUNK = WIDTH/STAGES.

Ports:
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- IN_VALID  input  1  operand transaction present
- IN_READY  output  1  block accepts the transaction this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- C_IN  input  1  carry-in; ignored when SUB=1
- SUB  input  1  0: A+B+C_IN; 1: A-B (computed as A+~B+1)
- OUT_VALID  output  1  result present
- OUT_READY  input  1  downstream accepts the result
- SUM  output  WIDTH  result, modulo 2^WIDTH
- CARRY  output  1  carry out of the MSB; for SUB, 1 = no borrow (A >= B unsigned)
- OVERFLOW  output  1  two's-complement signed overflow of the result

Behaviour:
- Reset (RST high at a clock edge):
  - All stage valid bits, SUM, CARRY and OVERFLOW clear to 0.
  - OUT_VALID = 0.
  - IN_READY is forced 0 while RST is high.
  - Reset mid-operation discards every in-flight transaction; nothing is emitted afterwards.
- Advance: ADV = !OUT_VALID || OUT_READY. IN_READY = ADV && !RST. This is a combinational path from OUT_READY to IN_READY, and it is allowed.
- Global stall: when ADV=0, every stage register, including bubbles, holds its value. When ADV=1, all stages shift by one.
- Acceptance occurs on an edge where IN_VALID && IN_READY. A, B, C_IN and SUB are captured at that edge.
  - SUB=1: B is replaced by ~B and carry-in by 1.
  - SUB=0: B is used as-is and carry-in is C_IN.
- Stage k (k = 0..STAGES-1):
  - Adds chunk k of A and effective B, plus the carry from stage k-1. Stage 0 uses the effective carry-in.
  - Registers the CHUNK-bit partial sum and the chunk carry-out.
  - Upper, not-yet-added operand chunks and already-computed lower sum chunks travel alongside in registers.
  - Each stage carries a valid bit. An invalid stage still shifts but produces no output.
- Latency and throughput:
  - With no stall, a transaction accepted at edge t shows OUT_VALID=1 with its result after edge t+STAGES-1.
  - STAGES=1 gives a single registered adder: the result is visible in the cycle after acceptance.
  - Throughput is 1 transaction/cycle when OUT_READY is held high.
- Outputs:
  - SUM, CARRY and OVERFLOW are registered, valid only while OUT_VALID=1, and held stable while OUT_VALID && !OUT_READY.
  - OVERFLOW = (a_msb == b_eff_msb) && (sum_msb != a_msb), where b_eff is the effective (possibly inverted) B.
- Ordering: results are emitted strictly in acceptance order. No drop, no duplication.
- IN_VALID while IN_READY=0: the transaction is not accepted. The source must hold it.
- Simultaneous output handshake and new acceptance in one cycle is legal and preserves full throughput.

Test Plan (WIDTH=16, STAGES=4 unless stated):
- After reset, A=0x00FF, B=0x0001, C_IN=0, SUB=0, OUT_READY=1 -> 4 cycles later SUM=0x0100, CARRY=0, OVERFLOW=0, OUT_VALID high for exactly 1 cycle.
- A=0xFFFF, B=0x0000, C_IN=1 (carry ripples through all 4 stages) -> SUM=0x0000, CARRY=1, OVERFLOW=0. Then A=0x7FFF, B=0x0001, C_IN=0 -> SUM=0x8000, CARRY=0, OVERFLOW=1.
- SUB=1, A=0x0005, B=0x0007, C_IN=1 (ignored) -> SUM=0xFFFE, CARRY=0, OVERFLOW=0. Then SUB=1, A=0x8000, B=0x0001 -> SUM=0x7FFF, CARRY=1, OVERFLOW=1.
- Back-to-back stream of 8 adds (A=i, B=0x1000·i) with OUT_READY low for cycles 6-9 -> IN_READY low whenever OUT_VALID && !OUT_READY. Outputs stay stable while stalled. All 8 results (0x1001·i) are emitted in order with no loss or duplication.
- RST asserted for 1 cycle with 3 transactions in flight -> OUT_VALID=0 next cycle and stays 0. No stale result appears. A post-reset transaction 0x1234+0x4321 yields 0x5555 after 4 cycles.
- Re-elaborate with STAGES=1 and with STAGES=16: 0xFFFF+0x0001 yields SUM=0x0000, CARRY=1 after latency 1 and 16 respectively. STAGES=3 with WIDTH=16 fails elaboration.
